mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Sequences the single byte-wide RAM port and shares it between instruction fetch (IF) and the MEM stage.
- Arbitrates between the two requesters, latches the granted request, and issues 1/2/4 single-byte RAM accesses in little-endian order.
- Assembles read data and returns a one-cycle done pulse.
- Exports per-requester stall levels that feed the pipeline stall controller.

Parameters:
ADDR_WIDTH, 32, width of requester and RAM addresses

Ports:
clk_in  input  1  clock
rst_in  input  1  reset, asynchronous, active-low
if_req_in  input  1  IF fetch request, level, held until if_done_out
if_addr_in  input  ADDR_WIDTH  fetch address
if_done_out  output  1  one-cycle pulse, if_data_out valid
if_data_out  output  32  fetched word
mem_req_in  input  1  MEM access request, level, held until mem_done_out
mem_we_in  input  1  1 = store, 0 = load
mem_len_in  input  2  00 = byte, 01 = half, 10/11 = word
mem_addr_in  input  ADDR_WIDTH  access base address
mem_wdata_in  input  32  store data, low bytes used
mem_done_out  output  1  one-cycle pulse, access complete
mem_rdata_out  output  32  load data, zero-extended
ram_addr_out  output  ADDR_WIDTH  RAM byte address
ram_we_out  output  1  RAM write enable
ram_wdata_out  output  8  RAM write byte
ram_rdata_in  input  8  RAM read byte, valid one cycle after its address
if_stall_out  output  1  if_req_in & ~if_done_out (combinational)
mem_stall_out  output  1  mem_req_in & ~mem_done_out (combinational)

Behaviour:
- Reset (rst_in low, asynchronous): state IDLE, counter 0, all registered outputs 0. This includes ram_addr_out, ram_we_out, ram_wdata_out, both done pulses and both data outputs.
- Reset mid-access: the access is abandoned; no done pulse is produced.
- Byte count N:
  - IF: always 4.
  - MEM: len 00 → 1, 01 → 2, 10/11 → 4.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Drives ram_we_out = 0 and ram_addr_out = 0.
  - If mem_req_in = 1: grant MEM. MEM has priority over IF because it is the older instruction.
  - Else if if_req_in = 1: grant IF.
  - On grant, latch owner, we, N, base address and wdata; clear counter k and the assembly register; go to BUSY.
- BUSY, read, cycle k = 0..N:
  - For k < N: ram_addr_out = base + k (mod 2^ADDR_WIDTH, no alignment check), ram_we_out = 0.
  - For k ≥ 1: capture ram_rdata_in into byte k-1 of the assembly register.
  - After k = N: go to DONE.
- BUSY, write, cycle k = 0..N-1:
  - ram_addr_out = base + k, ram_we_out = 1, ram_wdata_out = wdata byte k.
  - After k = N-1: go to DONE.
- DONE (one cycle):
  - The owner's done pulse is high. For reads, the owner's data output is updated, with unread upper bytes zero.
  - ram_we_out = 0.
  - No request is sampled in this cycle; next state is IDLE.
  - Requesters deassert req at the edge ending the done cycle.
- Data outputs hold their value until the same owner's next read completes. Writes leave mem_rdata_out unchanged.
- Inputs that change during BUSY/DONE are ignored; the latched values are used.
- Latency, request first seen in IDLE at cycle 0:
  - Read of N bytes: done in cycle N+2.
  - Write of N bytes: done in cycle N+1.
  - Word fetch: done in cycle 6.
- Both requests high in IDLE: MEM is served first. IF is sampled in the IDLE cycle after MEM's DONE, so IF waits N_mem+3 (read) or N_mem+2 (write) extra cycles.
- Exactly one done pulse per granted request; both done outputs are never high together.

Test Plan:
1. Reset mid-read: assert if_req_in, addr 0x100; drop rst_in at BUSY k=2 → FSM is IDLE immediately, all outputs are 0, and no if_done_out pulse appears.
2. IF word fetch: if_req_in = 1, addr 0x1000, RAM bytes 0x13, 0x05, 0x10, 0x00 → ram_addr_out is 0x1000..0x1003 in cycles 1-4, if_done_out is high in cycle 6 only, and if_data_out = 0x00100513.
3. MEM byte load: len 00, addr 0x2003, RAM byte 0xFF → mem_done_out in cycle 3, mem_rdata_out = 0x000000FF.
4. MEM half store: we = 1, len 01, addr 0x3000, wdata 0xDEADBEEF → ram_we_out = 1 with (0x3000, 0xEF) in cycle 1 and (0x3001, 0xBE) in cycle 2, mem_done_out in cycle 3, and there are no other writes.
5. Simultaneous requests: both requests high in cycle 0 (MEM word load) → MEM is served first with mem_done_out in cycle 6. IF is granted in cycle 7 and if_done_out arrives in cycle 13. if_stall_out stays high from cycle 0 through cycle 12.
6. Address wrap: MEM word load at 0xFFFFFFFE → addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: shares one byte-wide RAM port between instruction fetch and the MEM
// stage, issuing 1/2/4 little-endian byte accesses and returning assembled data.
module mem_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  if_req_in,
    input  logic [ADDR_WIDTH-1:0] if_addr_in,
    output logic                  if_done_out,
    output logic [31:0]           if_data_out,
    input  logic                  mem_req_in,
    input  logic                  mem_we_in,
    input  logic [1:0]            mem_len_in,
    input  logic [ADDR_WIDTH-1:0] mem_addr_in,
    input  logic [31:0]           mem_wdata_in,
    output logic                  mem_done_out,
    output logic [31:0]           mem_rdata_out,
    output logic [ADDR_WIDTH-1:0] ram_addr_out,
    output logic                  ram_we_out,
    output logic [7:0]            ram_wdata_out,
    input  logic [7:0]            ram_rdata_in,
    output logic                  if_stall_out,
    output logic                  mem_stall_out
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned NBYTES = DATA_W / BYTE_W;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state, state_d;
    logic [CNT_W-1:0]        cnt, cnt_d, cnt_nx;
    logic [CNT_W-1:0]        num, num_d;
    logic                    own_mem, own_mem_d;
    logic                    we, we_d;
    logic [ADDR_WIDTH-1:0]   base, base_d;
    logic [DATA_W-1:0]       wdata, wdata_d;
    logic [DATA_W-1:0]       asm_q, asm_d;

    logic [ADDR_WIDTH-1:0]   ram_addr_d;
    logic                    ram_we_d;
    logic [BYTE_W-1:0]       ram_wdata_d;
    logic                    if_done_d, mem_done_d;
    logic [DATA_W-1:0]       if_data_d, mem_rdata_d;

    function automatic logic [CNT_W-1:0] len_to_num(input logic [1:0] len);
        case (len)
            2'b00:   return CNT_W'(1);
            2'b01:   return CNT_W'(2);
            default: return CNT_W'(4);
        endcase
    endfunction

    // Stall levels drop in the same cycle the done pulse is seen.
    assign if_stall_out  = if_req_in & ~if_done_out;
    assign mem_stall_out = mem_req_in & ~mem_done_out;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state         <= IDLE;
            cnt           <= '0;
            num           <= '0;
            own_mem       <= 1'b0;
            we            <= 1'b0;
            base          <= '0;
            wdata         <= '0;
            asm_q         <= '0;
            ram_addr_out  <= '0;
            ram_we_out    <= 1'b0;
            ram_wdata_out <= '0;
            if_done_out   <= 1'b0;
            mem_done_out  <= 1'b0;
            if_data_out   <= '0;
            mem_rdata_out <= '0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            num           <= num_d;
            own_mem       <= own_mem_d;
            we            <= we_d;
            base          <= base_d;
            wdata         <= wdata_d;
            asm_q         <= asm_d;
            ram_addr_out  <= ram_addr_d;
            ram_we_out    <= ram_we_d;
            ram_wdata_out <= ram_wdata_d;
            if_done_out   <= if_done_d;
            mem_done_out  <= mem_done_d;
            if_data_out   <= if_data_d;
            mem_rdata_out <= mem_rdata_d;
        end
    end

    // Registered RAM outputs are computed one cycle ahead so address k is
    // presented during the cycle whose counter value is k.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        num_d       = num;
        own_mem_d   = own_mem;
        we_d        = we;
        base_d      = base;
        wdata_d     = wdata;
        asm_d       = asm_q;
        ram_addr_d  = '0;
        ram_we_d    = 1'b0;
        ram_wdata_d = '0;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_data_d   = if_data_out;
        mem_rdata_d = mem_rdata_out;
        cnt_nx      = cnt + CNT_W'(1);

        unique case (state)
            IDLE: begin
                if (mem_req_in || if_req_in) begin
                    own_mem_d   = mem_req_in;
                    we_d        = mem_req_in & mem_we_in;
                    num_d       = mem_req_in ? len_to_num(mem_len_in) : CNT_W'(NBYTES);
                    base_d      = mem_req_in ? mem_addr_in : if_addr_in;
                    wdata_d     = mem_req_in ? mem_wdata_in : '0;
                    cnt_d       = '0;
                    asm_d       = '0;
                    ram_addr_d  = base_d;
                    ram_we_d    = we_d;
                    ram_wdata_d = wdata_d[BYTE_W-1:0];
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (we) begin
                    if (cnt == num - CNT_W'(1)) begin
                        state_d    = DONE;
                        if_done_d  = ~own_mem;
                        mem_done_d = own_mem;
                    end else begin
                        cnt_d       = cnt_nx;
                        ram_addr_d  = base + ADDR_WIDTH'(cnt_nx);
                        ram_we_d    = 1'b1;
                        ram_wdata_d = BYTE_W'(wdata >> {cnt_nx[1:0], 3'b000});
                    end
                end else begin
                    // Byte k-1 returns while the counter reads k.
                    for (int b = 0; b < int'(NBYTES); b++) begin
                        if (cnt == CNT_W'(b + 1)) begin
                            asm_d[b*BYTE_W +: BYTE_W] = ram_rdata_in;
                        end
                    end
                    if (cnt == num) begin
                        state_d = DONE;
                        if (own_mem) begin
                            mem_done_d  = 1'b1;
                            mem_rdata_d = asm_d;
                        end else begin
                            if_done_d = 1'b1;
                            if_data_d = asm_d;
                        end
                    end else begin
                        cnt_d = cnt_nx;
                        if (cnt_nx < num) begin
                            ram_addr_d = base + ADDR_WIDTH'(cnt_nx);
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized scoreboard bench for mem_ctrl against a
// transaction-level model of the byte RAM.
module tb_mem_ctrl;
    logic        clk_in;
    logic        rst_in;
    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic        if_done_out;
    logic [31:0] if_data_out;
    logic        mem_req_in;
    logic        mem_we_in;
    logic [1:0]  mem_len_in;
    logic [31:0] mem_addr_in;
    logic [31:0] mem_wdata_in;
    logic        mem_done_out;
    logic [31:0] mem_rdata_out;
    logic [31:0] ram_addr_out;
    logic        ram_we_out;
    logic [7:0]  ram_wdata_out;
    logic [7:0]  ram_rdata_in;
    logic        if_stall_out;
    logic        mem_stall_out;

    mem_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .if_req_in(if_req_in), .if_addr_in(if_addr_in),
        .if_done_out(if_done_out), .if_data_out(if_data_out),
        .mem_req_in(mem_req_in), .mem_we_in(mem_we_in), .mem_len_in(mem_len_in),
        .mem_addr_in(mem_addr_in), .mem_wdata_in(mem_wdata_in),
        .mem_done_out(mem_done_out), .mem_rdata_out(mem_rdata_out),
        .ram_addr_out(ram_addr_out), .ram_we_out(ram_we_out),
        .ram_wdata_out(ram_wdata_out), .ram_rdata_in(ram_rdata_in),
        .if_stall_out(if_stall_out), .mem_stall_out(mem_stall_out)
    );

    typedef struct {
        logic [31:0] data;
        logic        we;
        int unsigned cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    exp_t        if_q[$];
    exp_t        mem_q[$];
    wr_t         wr_q[$];
    logic [7:0]  ref_mem [logic [31:0]];
    logic [7:0]  ram     [logic [31:0]];
    logic [31:0] if_hold  = '0;
    logic [31:0] mem_hold = '0;
    int unsigned cyc      = 0;
    int          chk_cnt  = 0;
    int          pass_cnt = 0;

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h9E3779B1;
        return h[31:24] ^ h[15:8] ^ a[7:0];
    endfunction

    function automatic logic [7:0] ram_read(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    // Byte RAM: write on the edge, read data one cycle after the address.
    always @(posedge clk_in) begin
        if (ram_we_out) ram[ram_addr_out] = ram_wdata_out;
        ram_rdata_in <= ram_read(ram_addr_out);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        chk_cnt++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        ram[a]     = d;
        ref_mem[a] = d;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ram_addr"}, ram_addr_out, 32'h0);
        check({tag, "_ram_we"}, 32'(ram_we_out), 32'h0);
        check({tag, "_ram_wdata"}, 32'(ram_wdata_out), 32'h0);
        check({tag, "_if_done"}, 32'(if_done_out), 32'h0);
        check({tag, "_mem_done"}, 32'(mem_done_out), 32'h0);
        check({tag, "_if_data"}, if_data_out, 32'h0);
        check({tag, "_mem_rdata"}, mem_rdata_out, 32'h0);
    endtask

    // Monitor: stall levels every cycle, done pulses and RAM writes against the queues.
    always @(negedge clk_in) begin
        exp_t e;
        wr_t  w;
        check("if_stall", 32'(if_stall_out), 32'(if_req_in & ~if_done_out));
        check("mem_stall", 32'(mem_stall_out), 32'(mem_req_in & ~mem_done_out));
        if (mem_done_out) begin
            check("done_exclusive", 32'(if_done_out), 32'h0);
            if (mem_q.size() == 0) fail_now("mem_done_unexpected");
            else begin
                e = mem_q.pop_front();
                check("mem_done_cycle", cyc, e.cyc);
                if (!e.we) mem_hold = e.data;
                check("mem_rdata", mem_rdata_out, mem_hold);
            end
        end
        if (if_done_out) begin
            if (if_q.size() == 0) fail_now("if_done_unexpected");
            else begin
                e = if_q.pop_front();
                check("if_done_cycle", cyc, e.cyc);
                if_hold = e.data;
                check("if_data", if_data_out, if_hold);
            end
        end
        if (ram_we_out) begin
            if (wr_q.size() == 0) fail_now("ram_write_unexpected");
            else begin
                w = wr_q.pop_front();
                check("ram_write_addr", ram_addr_out, w.addr);
                check("ram_write_data", 32'(ram_wdata_out), 32'(w.data));
            end
        end
    end

    task automatic do_mem(input logic we, input logic [1:0] len, input logic [31:0] addr,
                          input logic [31:0] wdata, input int unsigned extra);
        int unsigned n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
        exp_t e;
        wr_t  w;
        bit   seen = 0;
        e.we   = we;
        e.data = '0;
        for (int i = 0; i < int'(n); i++) begin
            if (we) begin
                ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
                w.addr = addr + 32'(i);
                w.data = wdata[8*i +: 8];
                wr_q.push_back(w);
            end else begin
                e.data[8*i +: 8] = ref_read(addr + 32'(i));
            end
        end
        @(posedge clk_in); #1;
        mem_req_in = 1'b1; mem_we_in = we; mem_len_in = len;
        mem_addr_in = addr; mem_wdata_in = wdata;
        e.cyc = cyc + extra + n + (we ? 1 : 2);
        mem_q.push_back(e);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_in);
            if (mem_done_out) begin seen = 1; break; end
            if (i > 0) begin
                // Latched request: these changes must have no effect.
                mem_addr_in  = $urandom;
                mem_wdata_in = $urandom;
                mem_len_in   = 2'($urandom_range(0, 3));
                mem_we_in    = 1'($urandom_range(0, 1));
            end
        end
        if (!seen) fail_now("mem_done_timeout");
        @(posedge clk_in); #1;
        mem_req_in = 1'b0;
    endtask

    task automatic do_if(input logic [31:0] addr, input int unsigned extra);
        exp_t e;
        bit   seen = 0;
        e.we   = 1'b0;
        for (int i = 0; i < 4; i++) e.data[8*i +: 8] = ref_read(addr + 32'(i));
        @(posedge clk_in); #1;
        if_req_in = 1'b1; if_addr_in = addr;
        e.cyc = cyc + extra + 6;
        if_q.push_back(e);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_in);
            if (if_done_out) begin seen = 1; break; end
        end
        if (!seen) fail_now("if_done_timeout");
        @(posedge clk_in); #1;
        if_req_in = 1'b0;
    endtask

    initial begin
        #500000;
        fail_now("global_timeout");
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [1:0]  len;
        logic [31:0] a;
        clk_in = 1'b0; rst_in = 1'b0;
        if_req_in = 1'b0; if_addr_in = '0;
        mem_req_in = 1'b0; mem_we_in = 1'b0; mem_len_in = '0;
        mem_addr_in = '0; mem_wdata_in = '0;
        repeat (2) @(negedge clk_in);
        check_zero("reset");
        rst_in = 1'b1;

        preload(32'h1000, 8'h13); preload(32'h1001, 8'h05);
        preload(32'h1002, 8'h10); preload(32'h1003, 8'h00);
        preload(32'h2003, 8'hFF);

        do_if(32'h1000, 0);
        check("fetch_word", if_hold, 32'h00100513);
        do_mem(1'b0, 2'b00, 32'h2003, 32'h0, 0);
        check("byte_load", mem_hold, 32'h000000FF);
        do_mem(1'b1, 2'b01, 32'h3000, 32'hDEADBEEF, 0);
        do_mem(1'b0, 2'b01, 32'h3000, 32'h0, 0);
        check("half_readback", mem_hold, 32'h0000BEEF);
        fork
            do_mem(1'b0, 2'b10, 32'h1000, 32'h0, 0);
            do_if(32'h5000, 7);
        join
        do_mem(1'b0, 2'b11, 32'hFFFFFFFE, 32'h0, 0);

        for (int t = 0; t < 60; t++) begin
            len = 2'($urandom_range(0, 3));
            a   = 32'h4000 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 4) == 0) begin
                fork
                    do_mem(1'b0, len, a, 32'h0, 0);
                    do_if(32'h4000 + 32'($urandom_range(0, 63)), (len == 2'b00) ? 4 : (len == 2'b01) ? 5 : 7);
                join
            end else if ($urandom_range(0, 2) == 0) begin
                do_if(a, 0);
            end else begin
                do_mem(1'($urandom_range(0, 1)), len, a, $urandom, 0);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk_in);
        end

        // Reset while the fetch is at its third byte.
        @(posedge clk_in); #1;
        if_req_in = 1'b1; if_addr_in = 32'h100;
        repeat (3) @(posedge clk_in);
        #2;
        rst_in = 1'b0;
        #1;
        check_zero("midreset");
        if_req_in = 1'b0;
        if_hold = '0; mem_hold = '0;
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (8) begin
            @(negedge clk_in);
            check("post_reset_idle_addr", ram_addr_out, 32'h0);
        end
        do_if(32'h1000, 0);

        repeat (5) @(negedge clk_in);
        check("if_q_drained", if_q.size(), 0);
        check("mem_q_drained", mem_q.size(), 0);
        check("wr_q_drained", wr_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
